// File: rtl/cu_pkg.sv
// Shared constants for the accumulator CPU microsequencer: opcodes, control-bit indices, state codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cu_pkg;

  localparam int CTRL_W = 16;
  localparam int OP_W   = 8;

  // Opcodes (IR[15:8])
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_AND    = 8'h08;
  localparam logic [7:0] OP_OR     = 8'h09;
  localparam logic [7:0] OP_SHL    = 8'h0A;

  // Control-bit positions within ctrl; bit 15 is reserved and never driven high
  localparam int C_MAR_PC  = 0;
  localparam int C_MBR_MEM = 1;
  localparam int C_MEM_MBR = 2;
  localparam int C_IR_MBR  = 3;
  localparam int C_MAR_MBR = 4;
  localparam int C_MBR_ACC = 5;
  localparam int C_PC_INC  = 6;
  localparam int C_BR_MBR  = 7;
  localparam int C_ACC_BR  = 8;
  localparam int C_ACC_ADD = 9;
  localparam int C_ACC_SUB = 10;
  localparam int C_ACC_AND = 11;
  localparam int C_ACC_OR  = 12;
  localparam int C_ACC_SHL = 13;
  localparam int C_PC_JMP  = 14;

  // State encoding; code 9 is unused and recovers to IDLE
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH0 = 4'd1;
  localparam logic [3:0] S_FETCH1 = 4'd2;
  localparam logic [3:0] S_FETCH2 = 4'd3;
  localparam logic [3:0] S_DECODE = 4'd4;
  localparam logic [3:0] S_RD     = 4'd5;
  localparam logic [3:0] S_ALU1   = 4'd6;
  localparam logic [3:0] S_ALU2   = 4'd7;
  localparam logic [3:0] S_WR     = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd10;

  // Every opcode from NOP through SHL is defined; anything above is illegal
  function automatic logic op_is_legal(input logic [7:0] op);
    return (op <= OP_SHL);
  endfunction

  // Opcodes that read an operand from memory and finish in the ALU
  function automatic logic op_is_read(input logic [7:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND)  || (op == OP_OR);
  endfunction

endpackage

// File: rtl/cu_ctrl_decode.sv
// Maps sequencer state, opcode, sign flag and memory-ready onto the C0..C15 control vector.
// Latency: purely combinational.
// Backpressure: memory-strobe bits appear only in the cycle mem_rdy is high.
module cu_ctrl_decode
  import cu_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int OP_W   = 8
) (
  input  logic [3:0]        state,
  input  logic [OP_W-1:0]   ir_op,
  input  logic [OP_W-1:0]   op_q,
  input  logic              acc_neg,
  input  logic              mem_rdy,
  output logic [CTRL_W-1:0] ctrl
);

  // One micro-op set per state; DECODE looks at the live IR, ALU2 at the latched opcode
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH0: ctrl[C_MAR_PC] = 1'b1;
      S_FETCH1: if (mem_rdy) begin
        ctrl[C_MBR_MEM] = 1'b1;
        ctrl[C_PC_INC]  = 1'b1;
      end
      S_FETCH2: ctrl[C_IR_MBR] = 1'b1;
      S_DECODE: begin
        case (ir_op)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: ctrl[C_MAR_MBR] = 1'b1;
          OP_STORE: begin
            ctrl[C_MAR_MBR] = 1'b1;
            ctrl[C_MBR_ACC] = 1'b1;
          end
          OP_JMP:    ctrl[C_PC_JMP] = 1'b1;
          OP_JMPGEZ: ctrl[C_PC_JMP] = ~acc_neg;
          OP_SHL:    ctrl[C_ACC_SHL] = 1'b1;
          default: ;
        endcase
      end
      S_RD:   if (mem_rdy) ctrl[C_MBR_MEM] = 1'b1;
      S_ALU1: ctrl[C_BR_MBR] = 1'b1;
      S_ALU2: begin
        case (op_q)
          OP_LOAD: ctrl[C_ACC_BR]  = 1'b1;
          OP_ADD:  ctrl[C_ACC_ADD] = 1'b1;
          OP_SUB:  ctrl[C_ACC_SUB] = 1'b1;
          OP_AND:  ctrl[C_ACC_AND] = 1'b1;
          OP_OR:   ctrl[C_ACC_OR]  = 1'b1;
          default: ;
        endcase
      end
      S_WR:   if (mem_rdy) ctrl[C_MEM_MBR] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microsequencer for the accumulator CPU: fetch/decode/execute with a memory read/write handshake.
// Latency: fetch 3 cycles, decode 1, then 0-3 execute cycles plus one per mem_rdy-low cycle.
// Backpressure: mem_rd/mem_wr are held and the sequencer stalls until mem_rdy.
module control_unit
  import cu_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   ir_op,
  input  logic              acc_neg,
  input  logic              mem_rdy,
  output logic [CTRL_W-1:0] ctrl,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              halted,
  output logic              illegal_op,
  output logic [3:0]        state_dbg
);

  logic [3:0]      state;
  logic [3:0]      state_nxt;
  logic [OP_W-1:0] op_q;

  cu_ctrl_decode #(
    .CTRL_W (CTRL_W),
    .OP_W   (OP_W)
  ) u_decode (
    .state   (state),
    .ir_op   (ir_op),
    .op_q    (op_q),
    .acc_neg (acc_neg),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  // Next-state selection; start and mem_rdy only matter in the states that wait on them
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH0;
      S_FETCH0: state_nxt = S_FETCH1;
      S_FETCH1: if (mem_rdy) state_nxt = S_FETCH2;
      S_FETCH2: state_nxt = S_DECODE;
      S_DECODE: begin
        if (op_is_read(ir_op))      state_nxt = S_RD;
        else if (ir_op == OP_STORE) state_nxt = S_WR;
        else if (ir_op == OP_HALT)  state_nxt = S_HALT;
        else                        state_nxt = S_FETCH0;
      end
      S_RD:     if (mem_rdy) state_nxt = S_ALU1;
      S_ALU1:   state_nxt = S_ALU2;
      S_ALU2:   state_nxt = S_FETCH0;
      S_WR:     if (mem_rdy) state_nxt = S_FETCH0;
      S_HALT:   if (start) state_nxt = S_FETCH0;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register and opcode latch; async reset drops every request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= ir_op;
    end
  end

  assign mem_rd     = (state == S_FETCH1) || (state == S_RD);
  assign mem_wr     = (state == S_WR);
  assign halted     = (state == S_HALT);
  assign illegal_op = (state == S_DECODE) && !op_is_legal(ir_op);
  assign state_dbg  = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: an instruction-level model expands each instruction into per-cycle stimulus and expected outputs.
// Latency: checks every cycle of every instruction, including memory wait cycles.
// Backpressure: mem_rdy is held low for chosen cycles in fetch, read and write.
module tb_control_unit;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  ir_op;
  logic        acc_neg;
  logic        mem_rdy;
  logic [15:0] ctrl;
  logic        mem_rd;
  logic        mem_wr;
  logic        halted;
  logic        illegal_op;
  logic [3:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        st;
    logic [7:0]  op;
    logic        neg;
    logic        rdy;
    logic [15:0] c;
    logic        rd;
    logic        wr;
    logic        hlt;
    logic        ill;
    logic [3:0]  s;
  } step_t;

  step_t       q[$];
  logic [15:0] log_c[$];

  control_unit #(.CTRL_W(16), .OP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ir_op      (ir_op),
    .acc_neg    (acc_neg),
    .mem_rdy    (mem_rdy),
    .ctrl       (ctrl),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .halted     (halted),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic st, input logic [7:0] op, input logic neg, input logic rdy,
                      input logic [15:0] c, input logic rd, input logic wr, input logic hlt,
                      input logic ill, input logic [3:0] s);
    step_t e;
    e.st = st; e.op = op; e.neg = neg; e.rdy = rdy; e.c = c;
    e.rd = rd; e.wr = wr; e.hlt = hlt; e.ill = ill; e.s = s;
    q.push_back(e);
  endtask

  // Expand one instruction into its cycles. ir_op carries junk outside DECODE so any
  // late use of the live IR shows up; start/mem_rdy are waved where they must be ignored.
  task automatic add_instr(input logic [7:0] op, input logic neg, input int fwait, input int mwait);
    logic [7:0]  junk;
    logic [15:0] dc;
    logic [15:0] alu;
    logic        ill;
    int          kind;
    junk = op ^ 8'h5A;
    dc = 16'h0000; alu = 16'h0000; ill = 1'b0; kind = 0;
    push(1'b0, junk, neg, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH0);
    for (int i = 0; i < fwait; i++)
      push(1'b0, junk, neg, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, S_FETCH1);
    push(1'b0, junk, neg, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0, S_FETCH1);
    push(1'b1, junk, neg, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH2);
    case (op)
      8'h00: ;
      8'h01: kind = 2;
      8'h02: begin kind = 1; alu = 16'h0100; end
      8'h03: begin kind = 1; alu = 16'h0200; end
      8'h04: begin kind = 1; alu = 16'h0400; end
      8'h05: dc = neg ? 16'h0000 : 16'h4000;
      8'h06: dc = 16'h4000;
      8'h07: kind = 3;
      8'h08: begin kind = 1; alu = 16'h0800; end
      8'h09: begin kind = 1; alu = 16'h1000; end
      8'h0A: dc = 16'h2000;
      default: ill = 1'b1;
    endcase
    if (kind == 1) dc = 16'h0010;
    if (kind == 2) dc = 16'h0030;
    push(1'b0, op, neg, 1'b1, dc, 1'b0, 1'b0, 1'b0, ill, S_DECODE);
    if (kind == 1) begin
      for (int i = 0; i < mwait; i++)
        push(1'b0, junk, neg, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, S_RD);
      push(1'b0, junk, neg, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, S_RD);
      push(1'b1, junk, neg, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, S_ALU1);
      push(1'b0, junk, neg, 1'b0, alu,      1'b0, 1'b0, 1'b0, 1'b0, S_ALU2);
    end else if (kind == 2) begin
      for (int i = 0; i < mwait; i++)
        push(1'b0, junk, neg, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, S_WR);
      push(1'b0, junk, neg, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, S_WR);
    end else if (kind == 3) begin
      for (int i = 0; i < 3; i++)
        push(1'b0, junk, neg, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, S_HALT);
      push(1'b1, junk, neg, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, S_HALT);
    end
  endtask

  initial begin
    int p_jmp, p_add, p_st, p_gez1;
    rst_n = 1'b0; start = 1'b0; ir_op = 8'h00; acc_neg = 1'b0; mem_rdy = 1'b1;
    #3;
    chk("reset ctrl",   ctrl, 16'h0000);
    chk("reset mem_rd", {15'd0, mem_rd}, 16'h0000);
    chk("reset mem_wr", {15'd0, mem_wr}, 16'h0000);
    chk("reset halted", {15'd0, halted}, 16'h0000);
    chk("reset illegal", {15'd0, illegal_op}, 16'h0000);
    chk("reset state",  {12'd0, state_dbg}, {12'd0, S_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // Program
    push(1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    push(1'b1, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    p_jmp = q.size();  add_instr(8'h06, 1'b0, 0, 0);
    p_add = q.size();  add_instr(8'h03, 1'b0, 0, 0);
    p_st  = q.size();  add_instr(8'h01, 1'b1, 0, 3);
    add_instr(8'h05, 1'b0, 0, 0);
    p_gez1 = q.size(); add_instr(8'h05, 1'b1, 0, 0);
    add_instr(8'h02, 1'b0, 2, 1);
    add_instr(8'h04, 1'b1, 0, 0);
    add_instr(8'h08, 1'b0, 1, 0);
    add_instr(8'h09, 1'b0, 0, 2);
    add_instr(8'h0A, 1'b0, 0, 0);
    add_instr(8'h00, 1'b0, 0, 0);
    add_instr(8'h07, 1'b0, 0, 0);
    add_instr(8'hFF, 1'b0, 0, 0);

    // Per-cycle compare against the expanded model
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = q[i].st; ir_op = q[i].op; acc_neg = q[i].neg; mem_rdy = q[i].rdy;
      #2;
      log_c.push_back(ctrl);
      chk($sformatf("step%0d ctrl", i), ctrl, q[i].c);
      chk($sformatf("step%0d mem_rd", i), {15'd0, mem_rd}, {15'd0, q[i].rd});
      chk($sformatf("step%0d mem_wr", i), {15'd0, mem_wr}, {15'd0, q[i].wr});
      chk($sformatf("step%0d halted", i), {15'd0, halted}, {15'd0, q[i].hlt});
      chk($sformatf("step%0d illegal", i), {15'd0, illegal_op}, {15'd0, q[i].ill});
      chk($sformatf("step%0d state", i), {12'd0, state_dbg}, {12'd0, q[i].s});
    end

    // Hand-computed traces pinning the model
    chk("jmp f0",   log_c[p_jmp + 0], 16'h0001);
    chk("jmp f1",   log_c[p_jmp + 1], 16'h0042);
    chk("jmp f2",   log_c[p_jmp + 2], 16'h0008);
    chk("jmp dec",  log_c[p_jmp + 3], 16'h4000);
    chk("jmp next", log_c[p_jmp + 4], 16'h0001);
    chk("add dec",  log_c[p_add + 3], 16'h0010);
    chk("add rd",   log_c[p_add + 4], 16'h0002);
    chk("add alu1", log_c[p_add + 5], 16'h0080);
    chk("add alu2", log_c[p_add + 6], 16'h0200);
    chk("add next", log_c[p_add + 7], 16'h0001);
    chk("st dec",   log_c[p_st + 3], 16'h0030);
    chk("st wait",  log_c[p_st + 5], 16'h0000);
    chk("st c2",    log_c[p_st + 7], 16'h0004);
    chk("gez neg dec", log_c[p_gez1 + 3], 16'h0000);
    chk("gez neg next", log_c[p_gez1 + 4], 16'h0001);

    // Reset while a fetch read is outstanding
    @(negedge clk);
    start = 1'b0; mem_rdy = 1'b0; ir_op = 8'h06;
    #2 chk("pre-rst state f0", {12'd0, state_dbg}, {12'd0, S_FETCH0});
    @(negedge clk);
    #2 chk("pre-rst mem_rd", {15'd0, mem_rd}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("rst mem_rd", {15'd0, mem_rd}, 16'h0000);
    chk("rst state",  {12'd0, state_dbg}, {12'd0, S_IDLE});
    chk("rst ctrl",   ctrl, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("post-rst%0d ctrl", i), ctrl, 16'h0000);
      chk($sformatf("post-rst%0d state", i), {12'd0, state_dbg}, {12'd0, S_IDLE});
      chk($sformatf("post-rst%0d mem_rd", i), {15'd0, mem_rd}, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
